pwm_capture: RTL and testbench

//  Receive-side counterpart of the LED PWM generator: measures an incoming PWM waveform.

---
 rtl/pwm_capture_pkg.sv | 18 +
 rtl/pwm_capture_div.sv | 74 +++++++
 rtl/pwm_capture.sv | 147 ++++++++++++++
 tb/tb_pwm_capture.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// ============================================================================
// pwm_capture_pkg : shared duty scale and capture FSM state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package pwm_capture_pkg;
  // Same duty scale as the LED PWM generator, so loopback values compare directly.
  localparam int c_DUTY_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DIVIDE  = 2'd2
  } cap_state_t;
endpackage

`default_nettype wire

// File: rtl/pwm_capture_div.sv
// ============================================================================
// pwm_capture_div : restoring divider, (i_num << DUTY_W) / i_den, 1 bit/cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_capture_div #(
  parameter int CNT_W  = 16,
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_num,
  input  logic [CNT_W-1:0]  i_den,
  output logic              o_busy,
  output logic              o_done,
  output logic [DUTY_W-1:0] o_quot
);
  localparam int c_CW = (DUTY_W > 1) ? $clog2(DUTY_W) : 1;

  logic              r_busy, r_done, r_sat;
  logic [c_CW-1:0]   r_cnt;
  logic [CNT_W-1:0]  r_rem, r_den;
  logic [DUTY_W-1:0] r_q;

  logic              w_go, w_ge;
  logic [CNT_W-1:0]  w_rem_in, w_den_in, w_rem_nx;
  logic [CNT_W:0]    w_shift;

  // The MSB is resolved in the start cycle itself, so done lands DUTY_W-1 cycles later.
  assign w_go     = i_start & ~r_busy;
  assign w_rem_in = w_go ? i_num : r_rem;
  assign w_den_in = w_go ? i_den : r_den;
  assign w_shift  = {w_rem_in, 1'b0};
  assign w_ge     = w_shift >= {1'b0, w_den_in};
  assign w_rem_nx = w_ge ? (w_shift[CNT_W-1:0] - w_den_in) : w_shift[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sat  <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_den  <= '0;
      r_q    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_go) begin
        r_busy <= 1'b1;
        r_cnt  <= c_CW'(DUTY_W - 1);
        r_sat  <= (i_num >= i_den);
        r_den  <= i_den;
        r_rem  <= w_rem_nx;
        r_q    <= {{(DUTY_W-1){1'b0}}, w_ge};
      end else if (r_busy) begin
        r_rem <= w_rem_nx;
        r_q   <= {r_q[DUTY_W-2:0], w_ge};
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == c_CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_quot = r_sat ? {DUTY_W{1'b1}} : r_q;
endmodule

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
// pwm_capture : measures period, high time and 0..2^DUTY_W-1 duty of a PWM pin
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DUTY_W      = c_DUTY_W_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pwm,
  output logic [CNT_W-1:0]  o_period,
  output logic [CNT_W-1:0]  o_high_time,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_valid,
  output logic              o_overrun,
  output logic              o_stuck_hi,
  output logic              o_stuck_lo
);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_prev;
  logic [CNT_W-1:0]       r_per, r_hi, r_lat_per, r_lat_hi;
  logic [CNT_W-1:0]       r_period, r_high;
  logic [DUTY_W-1:0]      r_duty;
  logic                   r_valid, r_overrun, r_stuck_hi, r_stuck_lo;
  cap_state_t             r_state;

  logic                   w_s, w_edge, w_per_sat, w_timeout, w_start;
  logic                   w_div_busy, w_div_done;
  logic [CNT_W-1:0]       w_per_len;
  logic [DUTY_W-1:0]      w_quot;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_edge    = w_s & ~r_s_prev;
  assign w_per_sat = (r_per == c_CNT_MAX);
  assign w_timeout = (r_per >= c_TIMEOUT);
  assign w_per_len = r_per + 1'b1;
  assign w_start   = (r_state == ST_MEASURE) && w_edge && !w_per_sat && !w_div_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_s_prev <= 1'b0;
      r_per    <= '0;
      r_hi     <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_pwm};
      r_s_prev <= w_s;
      if (w_edge) begin
        r_per <= '0;
        r_hi  <= CNT_W'(1);
      end else begin
        if (!w_per_sat) r_per <= r_per + 1'b1;
        if (w_s && r_hi != c_CNT_MAX) r_hi <= r_hi + 1'b1;
      end
    end
  end

  pwm_capture_div #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_num   (r_hi),
    .i_den   (w_per_len),
    .o_busy  (w_div_busy),
    .o_done  (w_div_done),
    .o_quot  (w_quot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lat_per  <= '0;
      r_lat_hi   <= '0;
      r_period   <= '0;
      r_high     <= '0;
      r_duty     <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      r_stuck_hi <= 1'b0;
      r_stuck_lo <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      if (w_edge) begin
        r_stuck_hi <= 1'b0;
        r_stuck_lo <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_edge) r_state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (w_edge) begin
            if (w_start) begin
              r_lat_per <= w_per_len;
              r_lat_hi  <= r_hi;
              r_state   <= ST_DIVIDE;
            end
          end else if (w_timeout) begin
            r_stuck_hi <= w_s;
            r_stuck_lo <= ~w_s;
            r_duty     <= {DUTY_W{w_s}};
            r_period   <= '0;
            r_high     <= '0;
            r_valid    <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        ST_DIVIDE: begin
          // An edge here closes a measurement nobody can divide; drop it.
          if (w_edge) r_overrun <= 1'b1;
          if (w_div_done) begin
            r_period <= r_lat_per;
            r_high   <= r_lat_hi;
            r_duty   <= w_quot;
            r_valid  <= 1'b1;
            r_state  <= ST_MEASURE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_period    = r_period;
  assign o_high_time = r_high;
  assign o_duty      = r_duty;
  assign o_valid     = r_valid;
  assign o_overrun   = r_overrun;
  assign o_stuck_hi  = r_stuck_hi;
  assign o_stuck_lo  = r_stuck_lo;
endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
// tb_pwm_capture : random and directed PWM stimulus against a timestamp model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pwm_capture;
  localparam int TO = 1000;
  localparam int HMAX = 65536;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_in = 1'b0;
  logic [15:0] o_period, o_high_time;
  logic [7:0]  o_duty;
  logic        o_valid, o_overrun, o_stuck_hi, o_stuck_lo;

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  bit xh [HMAX];
  bit rh [HMAX];

  // Model state: timestamps of edges and pending divide result.
  localparam int M_IDLE = 0, M_MEAS = 1, M_DIV = 2;
  int m_mode, m_last, m_hi, m_done_t, p_per, p_hi, p_duty;
  bit have_exp = 1'b0;
  logic        e_valid, e_ovr, e_shi, e_slo;
  logic [15:0] e_per, e_hi;
  logic [7:0]  e_duty;

  int n_valid = 0, n_ovr = 0;
  logic [15:0] lv_per, lv_hi;
  logic [7:0]  lv_duty;

  pwm_capture #(.CNT_W(16), .DUTY_W(8), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_pwm(pwm_in),
    .o_period(o_period), .o_high_time(o_high_time), .o_duty(o_duty),
    .o_valid(o_valid), .o_overrun(o_overrun),
    .o_stuck_hi(o_stuck_hi), .o_stuck_lo(o_stuck_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int t, pp, hh, dd;
    bit s, sp, edg;
    t = cyc;
    if (have_exp) begin
      n_total++;
      if ({o_valid, o_overrun, o_stuck_hi, o_stuck_lo, o_period, o_high_time, o_duty} !==
          {e_valid, e_ovr, e_shi, e_slo, e_per, e_hi, e_duty}) begin
        n_bad++;
        $display("FAIL model cyc=%0d got v=%0d ov=%0d shi=%0d slo=%0d per=%0d hi=%0d duty=%0d want v=%0d ov=%0d shi=%0d slo=%0d per=%0d hi=%0d duty=%0d",
                 t, o_valid, o_overrun, o_stuck_hi, o_stuck_lo, o_period, o_high_time, o_duty,
                 e_valid, e_ovr, e_shi, e_slo, e_per, e_hi, e_duty);
      end
    end
    if (o_valid === 1'b1) begin
      n_valid++; lv_per = o_period; lv_hi = o_high_time; lv_duty = o_duty;
    end
    if (o_overrun === 1'b1) n_ovr++;

    if (rh[t]) begin
      // Reset flushes the synchroniser: samples in flight are lost.
      for (int k = 0; k < 3; k++) if (t - k >= 0) xh[t-k] = 1'b0;
      m_mode = M_IDLE; m_last = 0; m_hi = 0; m_done_t = -1;
      {e_valid, e_ovr, e_shi, e_slo} = 4'b0;
      e_per = '0; e_hi = '0; e_duty = '0;
      have_exp = 1'b1;
    end else if (have_exp) begin
      s   = (t >= 2) ? xh[t-2] : 1'b0;
      sp  = (t >= 3) ? xh[t-3] : 1'b0;
      edg = s & ~sp;
      e_valid = 1'b0; e_ovr = 1'b0;
      if (edg) begin e_shi = 1'b0; e_slo = 1'b0; end
      case (m_mode)
        M_IDLE: if (edg) m_mode = M_MEAS;
        M_MEAS: begin
          if (edg) begin
            pp = t - m_last; hh = m_hi;
            dd = (hh * 256) / pp;
            p_per = pp; p_hi = hh; p_duty = (dd > 255) ? 255 : dd;
            m_done_t = t + 8;
            m_mode = M_DIV;
          end else if (t - m_last - 1 >= TO) begin
            e_valid = 1'b1; e_shi = s; e_slo = ~s;
            e_duty = s ? 8'd255 : 8'd0; e_per = '0; e_hi = '0;
            m_mode = M_IDLE;
          end
        end
        default: begin
          if (edg) e_ovr = 1'b1;
          if (t == m_done_t) begin
            e_valid = 1'b1; e_per = 16'(p_per); e_hi = 16'(p_hi); e_duty = 8'(p_duty);
            m_mode = M_MEAS;
          end
        end
      endcase
      if (edg) begin m_last = t; m_hi = 1; end
      else m_hi += int'(s);
    end
  end

  task automatic tick(input bit v, input bit r);
    @(posedge clk); #1;
    pwm_in = v; rst = r;
    if (cyc < HMAX) begin xh[cyc] = v; rh[cyc] = r; end
  endtask

  task automatic run_pwm(input int per, input int hi, input int reps);
    for (int k = 0; k < reps; k++)
      for (int c = 0; c < per; c++) tick(c < hi, 1'b0);
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  initial begin
    int c0, o0, p, h;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    check("reset_outputs", {o_valid, o_overrun, o_stuck_hi, o_stuck_lo, o_period, o_high_time, o_duty}, 0);

    o0 = n_ovr;
    run_pwm(256, 64, 6);
    check("p256_period", lv_per, 256);
    check("p256_high", lv_hi, 64);
    check("p256_duty", lv_duty, 64);
    check("p256_no_overrun", n_ovr - o0, 0);

    run_pwm(300, 100, 6);
    check("p300_period", lv_per, 300);
    check("p300_duty", lv_duty, 85);

    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    c0 = n_valid;
    for (int i = 20; i < 1200; i++) tick(1'b1, 1'b0);
    check("stuck_hi_set", o_stuck_hi, 1);
    check("stuck_hi_lo_clear", o_stuck_lo, 0);
    check("stuck_hi_duty", lv_duty, 255);
    check("stuck_hi_period", lv_per, 0);
    check("stuck_hi_single_valid", n_valid - c0, 1);
    run_pwm(256, 128, 4);
    check("resume_stuck_clear", o_stuck_hi, 0);
    check("resume_duty", lv_duty, 128);

    o0 = n_ovr;
    run_pwm(5, 2, 12);
    check("p5_overruns", (n_ovr - o0) >= 3, 1);
    check("p5_period", lv_per, 5);
    check("p5_high", lv_hi, 2);
    check("p5_duty", lv_duty, 102);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);

    run_pwm(50, 20, 2);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    @(negedge clk);
    check("mid_div_reset_outputs", {o_valid, o_overrun, o_stuck_hi, o_stuck_lo, o_period, o_high_time, o_duty}, 0);
    c0 = n_valid;
    for (int i = 0; i < 13; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0);
    check("first_edge_after_reset_no_valid", n_valid - c0, 0);

    for (int i = 0; i < 25; i++) begin
      p = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 11) : $urandom_range(12, 400);
      h = $urandom_range(1, p - 1);
      run_pwm(p, h, $urandom_range(1, 3));
      if (i % 9 == 4) for (int k = 0; k < 1050; k++) tick(1'b1, 1'b0);
      if (i % 8 == 7) for (int k = 0; k < 1100; k++) tick(1'b0, 1'b0);
    end
    run_pwm(256, 128, 3);
    check("final_duty", lv_duty, 128);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
